// File: rtl/lab1_sweep_ctrl.sv
// Sweep sequencer for the 3-input lab1 block: walks {A,B,C} through 0..7,
// samples D after a settle delay and scores it against an expected truth table.
module lab1_sweep_ctrl #(
  parameter int         SETTLE = 2,
  parameter logic [7:0] EXPECT = 8'h17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       D,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] captured,
  output logic [2:0] first_fail,
  output logic       fail_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] EXP_VEC     = EXPECT;

  state_t     state_r, state_nxt_s;
  logic [2:0] idx_r, idx_nxt_s;
  logic [3:0] wait_r;
  logic [2:0] abc_r;
  logic       busy_r, done_r, pass_r, fv_r;
  logic [3:0] err_r;
  logic [7:0] cap_r;
  logic [2:0] ff_r;
  logic       mismatch_s;
  logic       nxt_busy_s;

  assign mismatch_s = (D != EXP_VEC[idx_r]);
  assign nxt_busy_s = (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_SAMPLE);

  assign {A, B, C}  = abc_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign captured   = cap_r;
  assign first_fail = ff_r;
  assign fail_valid = fv_r;

  // Next-state and next-index selection; abort outranks every other transition.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SETTLE;
          idx_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (wait_r == SETTLE_LAST) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (idx_r == 3'd7) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SETTLE;
          idx_nxt_s   = idx_r + 3'd1;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, stimulus, status and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
      wait_r  <= 4'd0;
      abc_r   <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= 4'd0;
      cap_r   <= 8'h00;
      ff_r    <= 3'd0;
      fv_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      busy_r  <= nxt_busy_s;
      done_r  <= (state_nxt_s == ST_DONE);
      abc_r   <= nxt_busy_s ? idx_nxt_s : 3'd0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            wait_r <= 4'd0;
            err_r  <= 4'd0;
            cap_r  <= 8'h00;
            ff_r   <= 3'd0;
            fv_r   <= 1'b0;
            pass_r <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!abort) wait_r <= wait_r + 4'd1;
        end
        ST_SAMPLE: begin
          // An aborted sample is discarded entirely.
          if (!abort) begin
            cap_r[idx_r] <= D;
            wait_r       <= 4'd0;
            if (mismatch_s) err_r <= err_r + 4'd1;
            if (mismatch_s && !fv_r) begin
              ff_r <= idx_r;
              fv_r <= 1'b1;
            end
          end
        end
        ST_DONE:  pass_r <= (err_r == 4'd0);
        default:  pass_r <= pass_r;
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_sweep_ctrl.sv
// Directed bench for lab1_sweep_ctrl with a behavioural lab1 model and a
// result scoreboard; a second instance (SETTLE = 1) covers back-to-back sweeps.
module tb_lab1_sweep_ctrl;

  typedef struct packed {
    logic [7:0] cap;
    logic [3:0] err;
    logic [2:0] ff;
    logic       fv;
    logic       pass;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0, d;
  logic       a, b, c, busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [7:0] captured;
  logic [2:0] first_fail;

  logic       start1 = 1'b0, d1;
  logic       a1, b1, c1, busy1, done1, pass1, fail_valid1;
  logic [3:0] err_count1;
  logic [7:0] captured1;
  logic [2:0] first_fail1;

  int   mode = 0;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  lab1_sweep_ctrl #(.SETTLE(2), .EXPECT(8'h17)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .D(d),
    .A(a), .B(b), .C(c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .captured(captured), .first_fail(first_fail),
    .fail_valid(fail_valid)
  );

  lab1_sweep_ctrl #(.SETTLE(1), .EXPECT(8'h17)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(1'b0), .D(d1),
    .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .captured(captured1), .first_fail(first_fail1),
    .fail_valid(fail_valid1)
  );

  function automatic logic lab_d(input int m, input logic [2:0] v);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      0:       return ~maj;
      1:       return 1'b0;
      2:       return maj;
      default: return 1'b1;
    endcase
  endfunction

  always_comb d  = lab_d(mode, {a, b, c});
  always_comb d1 = lab_d(0, {a1, b1, c1});

  function automatic res_t model(input int m);
    res_t r;
    logic dv, ev;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      dv = lab_d(m, 3'(i));
      ev = lab_d(0, 3'(i));
      r.cap[i] = dv;
      if (dv != ev) begin
        r.err = r.err + 4'd1;
        if (!r.fv) begin
          r.ff = 3'(i);
          r.fv = 1'b1;
        end
      end
    end
    r.pass = (r.err == 4'd0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_res(input string tag, input bit which);
    res_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      if (!which) begin
        chk({tag, "_captured"}, captured, e.cap);
        chk({tag, "_err"}, err_count, e.err);
        chk({tag, "_ff"}, first_fail, e.ff);
        chk({tag, "_fv"}, fail_valid, e.fv);
        chk({tag, "_pass"}, pass, e.pass);
      end else begin
        chk({tag, "_captured"}, captured1, e.cap);
        chk({tag, "_err"}, err_count1, e.err);
        chk({tag, "_ff"}, first_fail1, e.ff);
        chk({tag, "_fv"}, fail_valid1, e.fv);
        chk({tag, "_pass"}, pass1, e.pass);
      end
    end
  endtask

  task automatic sweep0(input string tag, input int m);
    int n;
    mode = m;
    sb.push_back(model(m));
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_busy_len"}, n, 24);
    chk({tag, "_done_hi"}, done, 1);
    tick();
    chk({tag, "_done_lo"}, done, 0);
    check_res(tag, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_abc", {a, b, c}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_captured", captured, 0);
    chk("rst_fv", fail_valid, 0);
    #12 reset = 1'b0;
    tick();

    sweep0("good", 0);
    sweep0("tied0", 1);
    sweep0("maj", 2);

    // Abort in the SAMPLE cycle of idx 3 (edges 11..12 relative to accept)
    mode = 3;
    sb.push_back('{cap: 8'h07, err: 4'd0, ff: 3'd0, fv: 1'b0, pass: 1'b0});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("abort_pre_abc", {a, b, c}, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_abc", {a, b, c}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    check_res("abort", 1'b0);
    repeat (3) begin
      tick();
      chk("abort_no_done", done, 0);
    end

    // Asynchronous reset mid-SETTLE of idx 5
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("mid_abc", {a, b, c}, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_abc", {a, b, c}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_count, 0);
    chk("arst_captured", captured, 0);
    chk("arst_pass", pass, 0);
    reset = 1'b0;
    repeat (4) begin
      tick();
      chk("arst_no_resume", busy | done, 0);
    end
    sweep0("post_rst", 0);

    // start held high on the SETTLE = 1 instance
    sb.push_back(model(0));
    sb.push_back(model(0));
    start1 = 1'b1;
    tick();
    repeat (15) tick();
    chk("b2b_busy_last", busy1, 1);
    tick();
    chk("b2b_done1", done1, 1);
    chk("b2b_busy_off", busy1, 0);
    tick();
    chk("b2b_idle_done", done1, 0);
    chk("b2b_idle_busy", busy1, 0);
    check_res("b2b_first", 1'b1);
    tick();
    chk("b2b_reaccept", busy1, 1);
    repeat (16) tick();
    chk("b2b_done2", done1, 1);
    start1 = 1'b0;
    tick();
    check_res("b2b_second", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
